// File: rtl/vec_add_engine_pkg.sv
// Shared constants and types for the vector-add engine.
// Holds CSR offsets, the ID word, the FSM state enum and parameter defaults.
package vec_add_engine_pkg;

    localparam int ADDR_W_DEF = 11;
    localparam int DATA_W_DEF = 32;
    localparam int LEN_W      = 12;

    localparam logic [2:0] CSR_CTRL   = 3'd0;
    localparam logic [2:0] CSR_BASE_A = 3'd1;
    localparam logic [2:0] CSR_BASE_B = 3'd2;
    localparam logic [2:0] CSR_BASE_C = 3'd3;
    localparam logic [2:0] CSR_LEN    = 3'd4;
    localparam logic [2:0] CSR_STATUS = 3'd5;
    localparam logic [2:0] CSR_ID     = 3'd6;

    localparam logic [31:0] ID_VALUE = 32'h5EC0ADD1;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD_A = 3'd1,
        ST_RD_B = 3'd2,
        ST_WR_C = 3'd3,
        ST_DONE = 3'd4
    } state_t;

endpackage

// File: rtl/vec_add_engine.sv
// Vector add engine: C[i] = A[i] + B[i] over a single-port RAM, 3 cycles/element.
// Ports: clock/resetn; Avalon CSR (address, write, writedata, read, readdata);
//        RAM port (addr_arith, data_arith, we_arith, q_arith); done_irq pulse.
module vec_add_engine
    import vec_add_engine_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic [2:0]        address,
    input  logic              write,
    input  logic [31:0]       writedata,
    input  logic              read,
    output logic [31:0]       readdata,
    output logic [ADDR_W-1:0] addr_arith,
    output logic [DATA_W-1:0] data_arith,
    output logic              we_arith,
    input  logic [DATA_W-1:0] q_arith,
    output logic              done_irq
);

    state_t              r_state;
    state_t              w_next;

    logic [ADDR_W-1:0]   r_base_a;
    logic [ADDR_W-1:0]   r_base_b;
    logic [ADDR_W-1:0]   r_base_c;
    logic [LEN_W-1:0]    r_len;
    logic [LEN_W-1:0]    r_index;
    logic [DATA_W-1:0]   r_opa;
    logic                r_done;
    logic                r_carry;
    logic [31:0]         r_readdata;

    logic                w_busy;
    logic                w_ctrl_wr;
    logic                w_start;
    logic                w_abort;
    logic                w_last;
    logic [ADDR_W-1:0]   w_idx;
    logic [DATA_W:0]     w_sum;
    logic [31:0]         w_rdata;
    logic                w_unused;

    assign w_busy    = (r_state == ST_RD_A) ||
                       (r_state == ST_RD_B) ||
                       (r_state == ST_WR_C);
    assign w_ctrl_wr = write && (address == CSR_CTRL);
    assign w_start   = w_ctrl_wr && writedata[0];
    assign w_abort   = w_ctrl_wr && writedata[1];
    assign w_last    = (r_index + 12'd1) == r_len;
    assign w_idx     = ADDR_W'(r_index);
    // During WR_C, q_arith carries B[i] (addressed in RD_B).
    assign w_sum     = {1'b0, r_opa} + {1'b0, q_arith};
    assign w_unused  = ^writedata;
    assign readdata  = r_readdata;

    // State register
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; abort wins over every busy-state transition
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (w_start) begin
                    w_next = (r_len == 12'd0) ? ST_DONE : ST_RD_A;
                end
            end
            ST_RD_A: w_next = w_abort ? ST_IDLE : ST_RD_B;
            ST_RD_B: w_next = w_abort ? ST_IDLE : ST_WR_C;
            ST_WR_C: begin
                if (w_abort) begin
                    w_next = ST_IDLE;
                end else if (w_last) begin
                    w_next = ST_DONE;
                end else begin
                    w_next = ST_RD_A;
                end
            end
            ST_DONE: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    // Moore outputs straight from the state register, so reset
    // drops we_arith asynchronously
    always_comb begin
        addr_arith = '0;
        data_arith = '0;
        we_arith   = 1'b0;
        done_irq   = 1'b0;
        unique case (r_state)
            ST_RD_A: addr_arith = r_base_a + w_idx;
            ST_RD_B: addr_arith = r_base_b + w_idx;
            ST_WR_C: begin
                addr_arith = r_base_c + w_idx;
                data_arith = w_sum[DATA_W-1:0];
                we_arith   = 1'b1;
            end
            ST_DONE: done_irq = 1'b1;
            default: ;
        endcase
    end

    // Job datapath: index, operand A latch and status flags
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_index <= '0;
            r_opa   <= '0;
            r_done  <= 1'b0;
            r_carry <= 1'b0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (w_start && (r_len != 12'd0)) begin
                        r_index <= '0;
                        r_done  <= 1'b0;
                        r_carry <= 1'b0;
                    end
                end
                ST_RD_B: r_opa <= q_arith;
                ST_WR_C: begin
                    r_index <= r_index + 12'd1;
                    if (w_sum[DATA_W]) begin
                        r_carry <= 1'b1;
                    end
                end
                ST_DONE: r_done <= 1'b1;
                default: ;
            endcase
        end
    end

    // CSR read mux
    always_comb begin
        w_rdata = '0;
        unique case (address)
            CSR_BASE_A: w_rdata = 32'(r_base_a);
            CSR_BASE_B: w_rdata = 32'(r_base_b);
            CSR_BASE_C: w_rdata = 32'(r_base_c);
            CSR_LEN:    w_rdata = 32'(r_len);
            CSR_STATUS: w_rdata = {4'd0, r_index, 13'd0,
                                   r_carry, r_done, w_busy};
            CSR_ID:     w_rdata = ID_VALUE;
            default:    w_rdata = '0;
        endcase
    end

    // CSR register file; configuration is frozen while a job runs
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_base_a   <= '0;
            r_base_b   <= '0;
            r_base_c   <= '0;
            r_len      <= '0;
            r_readdata <= '0;
        end else begin
            if (write && !w_busy) begin
                unique case (address)
                    CSR_BASE_A: r_base_a <= writedata[ADDR_W-1:0];
                    CSR_BASE_B: r_base_b <= writedata[ADDR_W-1:0];
                    CSR_BASE_C: r_base_c <= writedata[ADDR_W-1:0];
                    CSR_LEN:    r_len    <= writedata[LEN_W-1:0];
                    default: ;
                endcase
            end
            if (read) begin
                r_readdata <= w_rdata;
            end
        end
    end

endmodule

// File: tb/tb_vec_add_engine.sv
// Self-checking bench for vec_add_engine with a 1-cycle-latency RAM model.
// Scoreboard checks every RAM write; table vectors and directed job sequences.
module tb_vec_add_engine;

    localparam int AW = 11;
    localparam int DW = 32;
    localparam logic [2:0] A_CTRL = 3'd0;
    localparam logic [2:0] A_BA   = 3'd1;
    localparam logic [2:0] A_BB   = 3'd2;
    localparam logic [2:0] A_BC   = 3'd3;
    localparam logic [2:0] A_LEN  = 3'd4;
    localparam logic [2:0] A_STAT = 3'd5;
    localparam logic [2:0] A_ID   = 3'd6;

    logic          clock = 1'b0;
    logic          resetn = 1'b0;
    logic [2:0]    address = '0;
    logic          write = 1'b0;
    logic [31:0]   writedata = '0;
    logic          read = 1'b0;
    logic [31:0]   readdata;
    logic [AW-1:0] addr_arith;
    logic [DW-1:0] data_arith;
    logic          we_arith;
    logic [DW-1:0] q_arith;
    logic          done_irq;

    vec_add_engine #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clock      (clock),
        .resetn     (resetn),
        .address    (address),
        .write      (write),
        .writedata  (writedata),
        .read       (read),
        .readdata   (readdata),
        .addr_arith (addr_arith),
        .data_arith (data_arith),
        .we_arith   (we_arith),
        .q_arith    (q_arith),
        .done_irq   (done_irq)
    );

    always #5 clock = ~clock;

    logic [DW-1:0] mem [0:(1<<AW)-1];

    always @(posedge clock) begin
        if (we_arith) mem[addr_arith] <= data_arith;
        else          q_arith <= mem[addr_arith];
    end

    typedef struct {
        logic [AW-1:0] a;
        logic [AW-1:0] b;
        logic [AW-1:0] c;
        logic [DW-1:0] d;
    } exp_t;

    typedef struct {
        logic [2:0]  a;
        logic [31:0] exp;
    } rd_vec_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] sum;
        logic        carry;
    } add_vec_t;

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    int wr_cnt = 0;
    int start_cyc = 0;

    exp_t          exp_q[$];
    logic [AW-1:0] a_log[$];
    logic [AW-1:0] h1 = '0;
    logic [AW-1:0] h2 = '0;

    rd_vec_t  rst_tab [8];
    add_vec_t add_tab [6];

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    always @(posedge clock) cyc <= cyc + 1;

    // Scoreboard monitor: sampled on the inactive edge
    always @(negedge clock) begin
        if (resetn) begin
            if (done_irq) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (we_arith) begin
                exp_t e;
                wr_cnt++;
                a_log.push_back(h2);
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_err++;
                    $display("FAIL unexpected_write: addr %0d data %h",
                             addr_arith, data_arith);
                end else begin
                    e = exp_q.pop_front();
                    check("wr_addr_c", 32'(addr_arith), 32'(e.c));
                    check("wr_data", data_arith, e.d);
                    check("rd_addr_a", 32'(h2), 32'(e.a));
                    check("rd_addr_b", 32'(h1), 32'(e.b));
                end
            end
            h2 = h1;
            h1 = addr_arith;
        end
    end

    task automatic csr_wr(input logic [2:0] a, input logic [31:0] d);
        @(negedge clock);
        address = a;
        writedata = d;
        write = 1'b1;
        @(negedge clock);
        write = 1'b0;
    endtask

    task automatic csr_rd(input logic [2:0] a, output logic [31:0] d);
        @(negedge clock);
        address = a;
        read = 1'b1;
        @(negedge clock);
        read = 1'b0;
        d = readdata;
    endtask

    task automatic setup(input int ba, input int bb, input int bc,
                         input int len);
        csr_wr(A_BA, 32'(ba));
        csr_wr(A_BB, 32'(bb));
        csr_wr(A_BC, 32'(bc));
        csr_wr(A_LEN, 32'(len));
    endtask

    task automatic push_job(input int ba, input int bb, input int bc,
                            input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            e.a = AW'(ba + i);
            e.b = AW'(bb + i);
            e.c = AW'(bc + i);
            e.d = mem[e.a] + mem[e.b];
            exp_q.push_back(e);
        end
    endtask

    task automatic start_job();
        csr_wr(A_CTRL, 32'h1);
        start_cyc = cyc;
    endtask

    task automatic wait_done(input string nm, input int d0,
                             input int budget);
        int k;
        for (k = 0; k < budget; k++) begin
            if (done_cnt > d0) break;
            @(negedge clock);
        end
        if (done_cnt <= d0) begin
            n_chk++;
            n_err++;
            $display("FAIL %s_timeout: no done_irq in %0d cycles",
                     nm, budget);
        end
    endtask

    task automatic run_job(input string nm, input int ba, input int bb,
                           input int bc, input int len,
                           output int lat);
        int d0;
        setup(ba, bb, bc, len);
        d0 = done_cnt;
        push_job(ba, bb, bc, len);
        start_job();
        wait_done(nm, d0, 3 * len + 10);
        lat = done_cyc - start_cyc;
        repeat (3) @(negedge clock);
        check({nm, "_sb_drain"}, 32'(exp_q.size()), 32'd0);
        check({nm, "_irq_count"}, 32'(done_cnt - d0), 32'd1);
        exp_q.delete();
    endtask

    task automatic check_csrs(input string nm);
        logic [31:0] d;
        for (int i = 0; i < 8; i++) begin
            csr_rd(rst_tab[i].a, d);
            check($sformatf("%s_csr%0d", nm, i), d, rst_tab[i].exp);
        end
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        int lat;
        int d0;
        int w0;
        logic hit;
        logic [31:0] exp_c [4];
        logic [AW-1:0] exp_a [4];

        for (int i = 0; i < 8; i++) begin
            rst_tab[i].a = 3'(i);
            rst_tab[i].exp = 32'h0;
        end
        rst_tab[6].exp = 32'h5EC0ADD1;

        add_tab[0] = '{32'h00000001, 32'h00000002, 32'h00000003, 1'b0};
        add_tab[1] = '{32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1};
        add_tab[2] = '{32'h80000000, 32'h80000000, 32'h00000000, 1'b1};
        add_tab[3] = '{32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0};
        add_tab[4] = '{32'h12345678, 32'h87654321, 32'h99999999, 1'b0};
        add_tab[5] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b1};

        for (int i = 0; i < (1 << AW); i++) mem[i] = '0;

        #3;
        check("rst_we", 32'(we_arith), 32'd0);
        check("rst_addr", 32'(addr_arith), 32'd0);
        check("rst_data", data_arith, 32'd0);
        check("rst_irq", 32'(done_irq), 32'd0);
        check("rst_readdata", readdata, 32'd0);
        repeat (2) @(negedge clock);
        resetn = 1'b1;
        check_csrs("post_reset");

        // Basic 4-element job
        for (int i = 0; i < 4; i++) begin
            mem[i] = 32'(i + 1);
            mem[16 + i] = 32'(10 * (i + 1));
        end
        exp_c = '{32'd11, 32'd22, 32'd33, 32'd44};
        run_job("basic", 0, 16, 32, 4, lat);
        check("basic_busy_cycles", 32'(lat), 32'd12);
        for (int i = 0; i < 4; i++)
            check($sformatf("basic_c%0d", i), mem[32 + i], exp_c[i]);
        csr_rd(A_STAT, d);
        check("basic_status", d, 32'h00040002);

        // Single-element table vectors
        for (int v = 0; v < 6; v++) begin
            mem[50] = add_tab[v].a;
            mem[60] = add_tab[v].b;
            run_job($sformatf("vec%0d", v), 50, 60, 70, 1, lat);
            check($sformatf("vec%0d_sum", v), mem[70], add_tab[v].sum);
            csr_rd(A_STAT, d);
            check($sformatf("vec%0d_status", v), d,
                  32'h00010002 | (32'(add_tab[v].carry) << 2));
        end

        // Address wrap at the top of the RAM
        mem[2046] = 32'd100;
        mem[2047] = 32'd200;
        for (int i = 0; i < 4; i++) mem[i] = 32'(i + 1);
        a_log.delete();
        run_job("wrap", 2046, 0, 1000, 4, lat);
        exp_a = '{11'd2046, 11'd2047, 11'd0, 11'd1};
        exp_c = '{32'd101, 32'd202, 32'd4, 32'd6};
        check("wrap_nreads", 32'(a_log.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < a_log.size())
                check($sformatf("wrap_a%0d", i), 32'(a_log[i]),
                      32'(exp_a[i]));
            check($sformatf("wrap_c%0d", i), mem[1000 + i], exp_c[i]);
        end

        // In-place: C overwrites A
        for (int i = 0; i < 3; i++) begin
            mem[400 + i] = 32'(5 + i);
            mem[420 + i] = 32'(100 * (i + 1));
        end
        exp_c = '{32'd105, 32'd206, 32'd307, 32'd0};
        run_job("inplace", 400, 420, 400, 3, lat);
        for (int i = 0; i < 3; i++)
            check($sformatf("inplace_c%0d", i), mem[400 + i], exp_c[i]);

        // Zero-length job
        w0 = wr_cnt;
        run_job("len0", 0, 16, 32, 0, lat);
        check("len0_latency", 32'(lat), 32'd0);
        check("len0_writes", 32'(wr_cnt - w0), 32'd0);
        csr_rd(A_STAT, d);
        check("len0_flags", {30'd0, d[1:0]}, 32'd2);

        // Config writes and start are ignored while busy
        setup(0, 16, 500, 2);
        d0 = done_cnt;
        push_job(0, 16, 500, 2);
        start_job();
        csr_wr(A_BA, 32'd123);
        csr_wr(A_CTRL, 32'h1);
        wait_done("busywr", d0, 20);
        lat = done_cyc - start_cyc;
        repeat (4) @(negedge clock);
        check("busywr_latency", 32'(lat), 32'd6);
        check("busywr_irq_count", 32'(done_cnt - d0), 32'd1);
        check("busywr_sb_drain", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        csr_rd(A_BA, d);
        check("busywr_base_a", d, 32'd0);

        // Abort during the second element of an 8-element job
        for (int i = 0; i < 8; i++) begin
            mem[100 + i] = 32'(i + 1);
            mem[200 + i] = 32'(10 * (i + 1));
            mem[300 + i] = 32'd0;
        end
        setup(100, 200, 300, 8);
        push_job(100, 200, 300, 1);
        d0 = done_cnt;
        w0 = wr_cnt;
        start_job();
        repeat (2) @(negedge clock);
        csr_wr(A_CTRL, 32'h2);
        repeat (5) @(negedge clock);
        check("abort_writes", 32'(wr_cnt - w0), 32'd1);
        check("abort_irq", 32'(done_cnt - d0), 32'd0);
        check("abort_sb_drain", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        check("abort_c0", mem[300], 32'd11);
        check("abort_c1", mem[301], 32'd0);
        csr_rd(A_STAT, d);
        check("abort_flags", {30'd0, d[1:0]}, 32'd0);
        run_job("after_abort", 100, 200, 300, 8, lat);
        check("after_abort_latency", 32'(lat), 32'd24);
        check("after_abort_c7", mem[307], 32'd88);

        // Reset pulse while a write is on the bus
        for (int i = 0; i < 4; i++) mem[600 + i] = 32'hDEADBEEF;
        setup(0, 16, 600, 4);
        push_job(0, 16, 600, 4);
        start_job();
        hit = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clock);
            if (we_arith) begin
                hit = 1'b1;
                break;
            end
        end
        check("midrst_saw_write", 32'(hit), 32'd1);
        #2 resetn = 1'b0;
        #1;
        check("midrst_we_drop", 32'(we_arith), 32'd0);
        check("midrst_addr", 32'(addr_arith), 32'd0);
        @(negedge clock);
        resetn = 1'b1;
        exp_q.delete();
        check("midrst_no_write", mem[600], 32'hDEADBEEF);
        check_csrs("post_midreset");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
